// File: rtl/cg_idle_ctrl.sv
// Clock-gate sequencing controller: wakes, holds and idles out the enable of a
// latch-based clock-gate cell, and keeps saturating gating statistics.
module cg_idle_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               busy,
  input  logic               force_on,
  input  logic               clr_stat,
  output logic               cg_en,
  output logic               ready,
  output logic [15:0]        off_cycles,
  output logic [7:0]         wake_events
);

  generate
    if (NUM_REQ < 1) begin : g_bad_num_req
      $error("cg_idle_ctrl: NUM_REQ must be >= 1");
    end
    if ((IDLE_CYCLES < 1) || (IDLE_CYCLES > 256)) begin : g_bad_idle
      $error("cg_idle_ctrl: IDLE_CYCLES must be in 1..256");
    end
    if ((WAKE_CYCLES < 1) || (WAKE_CYCLES > 256)) begin : g_bad_wake
      $error("cg_idle_ctrl: WAKE_CYCLES must be in 1..256");
    end
  endgenerate

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  wake_cnt_q, wake_cnt_d;
  logic [7:0]  idle_cnt_q, idle_cnt_d;
  logic        cg_en_q, cg_en_d;
  logic        ready_q, ready_d;
  logic [15:0] off_cycles_q, off_cycles_d;
  logic [7:0]  wake_events_q, wake_events_d;
  logic        act_s;
  logic        wake_start_s;

  assign act_s = (|req) | busy | force_on;

  // Next-state logic, plus outputs decoded from the next state so they are flop-driven
  always_comb begin
    state_d      = state_q;
    wake_cnt_d   = wake_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    wake_start_s = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (act_s) begin
          state_d      = ST_WAKE;
          wake_cnt_d   = 8'd0;
          wake_start_s = 1'b1;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_WAKE: begin
        // Wake always runs to completion regardless of activity.
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = ST_ON;
          idle_cnt_d = 8'd0;
        end else begin
          wake_cnt_d = wake_cnt_q + 8'd1;
        end
      end
      ST_ON: begin
        if (act_s) begin
          idle_cnt_d = 8'd0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      ST_DRAIN: begin
        if (act_s) begin
          state_d    = ST_ON;
          idle_cnt_d = 8'd0;
        end else begin
          state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase

    if (state_d != ST_OFF) begin
      cg_en_d = 1'b1;
    end else begin
      cg_en_d = 1'b0;
    end
    if (state_d == ST_ON) begin
      ready_d = 1'b1;
    end else begin
      ready_d = 1'b0;
    end
  end

  // Saturating statistics; a clear wins over that cycle's increment
  always_comb begin
    off_cycles_d  = off_cycles_q;
    wake_events_d = wake_events_q;
    if (clr_stat) begin
      off_cycles_d  = 16'd0;
      wake_events_d = 8'd0;
    end else begin
      if ((state_q == ST_OFF) && (off_cycles_q != 16'hFFFF)) begin
        off_cycles_d = off_cycles_q + 16'd1;
      end else begin
        off_cycles_d = off_cycles_q;
      end
      if (wake_start_s && (wake_events_q != 8'hFF)) begin
        wake_events_d = wake_events_q + 8'd1;
      end else begin
        wake_events_d = wake_events_q;
      end
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_OFF;
      wake_cnt_q    <= 8'd0;
      idle_cnt_q    <= 8'd0;
      cg_en_q       <= 1'b0;
      ready_q       <= 1'b0;
      off_cycles_q  <= 16'd0;
      wake_events_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      wake_cnt_q    <= wake_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      cg_en_q       <= cg_en_d;
      ready_q       <= ready_d;
      off_cycles_q  <= off_cycles_d;
      wake_events_q <= wake_events_d;
    end
  end

  assign cg_en       = cg_en_q;
  assign ready       = ready_q;
  assign off_cycles  = off_cycles_q;
  assign wake_events = wake_events_q;

endmodule

// File: tb/tb_cg_idle_ctrl.sv
// Self-checking bench for cg_idle_ctrl: per-cycle expectations are queued as
// stimulus is applied and popped/compared after the following clock edge.
module tb_cg_idle_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic        busy;
  logic        force_on;
  logic        clr_stat;
  logic        cg_en;
  logic        ready;
  logic [15:0] off_cycles;
  logic [7:0]  wake_events;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic        cg;
    logic        rdy;
    logic [15:0] off;
    logic [7:0]  wk;
  } exp_t;

  exp_t sb_q[$];

  // Bench-side expectations for the statistics counters
  logic        prev_cg;
  logic [15:0] exp_off;
  logic [7:0]  exp_wake;

  cg_idle_ctrl #(
    .NUM_REQ(4),
    .IDLE_CYCLES(16),
    .WAKE_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .busy(busy),
    .force_on(force_on),
    .clr_stat(clr_stat),
    .cg_en(cg_en),
    .ready(ready),
    .off_cycles(off_cycles),
    .wake_events(wake_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: queue the expected post-edge outputs, advance, then compare.
  task automatic step(input string tag, input logic exp_cg, input logic exp_rdy);
    exp_t e;
    exp_t o;
    if (clr_stat) begin
      exp_off  = 16'd0;
      exp_wake = 8'd0;
    end else begin
      if (!prev_cg && exp_off != 16'hFFFF) exp_off = exp_off + 16'd1;
      if (!prev_cg && exp_cg && exp_wake != 8'hFF) exp_wake = exp_wake + 8'd1;
    end
    prev_cg = exp_cg;
    e.tag = tag; e.cg = exp_cg; e.rdy = exp_rdy; e.off = exp_off; e.wk = exp_wake;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    check_eq({o.tag, ".cg_en"},  {31'd0, cg_en}, {31'd0, o.cg});
    check_eq({o.tag, ".ready"},  {31'd0, ready}, {31'd0, o.rdy});
    check_eq({o.tag, ".off"},    {16'd0, off_cycles}, {16'd0, o.off});
    check_eq({o.tag, ".wake"},   {24'd0, wake_events}, {24'd0, o.wk});
  endtask

  // Single-cycle request pulse on an OFF controller, through WAKE into ON.
  task automatic wake_up(input string tag, input logic [3:0] r);
    req = r;
    step({tag, "_e0"}, 1'b1, 1'b0);
    req = 4'd0;
    step({tag, "_e1"}, 1'b1, 1'b0);
    step({tag, "_e2"}, 1'b1, 1'b1);
  endtask

  // From ON with idle count 0 and no activity: idle window, DRAIN, OFF.
  task automatic idle_out(input string tag);
    for (int i = 1; i <= 15; i++) step({tag, "_idle"}, 1'b1, 1'b1);
    step({tag, "_drain"}, 1'b1, 1'b0);
    step({tag, "_off"}, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req = 4'd0; busy = 1'b0; force_on = 1'b0; clr_stat = 1'b0;
    prev_cg = 1'b0; exp_off = 16'd0; exp_wake = 8'd0;

    // Reset / idle
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.cg_en", {31'd0, cg_en}, 32'd0);
    check_eq("rst.ready", {31'd0, ready}, 32'd0);
    check_eq("rst.off",   {16'd0, off_cycles}, 32'd0);
    check_eq("rst.wake",  {24'd0, wake_events}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step("idle", 1'b0, 1'b0);
    check_eq("idle.off20", {16'd0, off_cycles}, 32'd20);

    // Basic wake and shutdown
    wake_up("wake", 4'b0010);
    idle_out("wake");

    // Activity at idle count 10 restarts the full window
    wake_up("restart", 4'b0001);
    for (int i = 0; i < 10; i++) step("restart_pre", 1'b1, 1'b1);
    busy = 1'b1;
    step("restart_busy", 1'b1, 1'b1);
    busy = 1'b0;
    idle_out("restart");

    // Activity exactly on the DRAIN cycle returns to ON without dropping cg_en
    wake_up("rescue", 4'b0100);
    for (int i = 1; i <= 15; i++) step("rescue_idle", 1'b1, 1'b1);
    step("rescue_drain", 1'b1, 1'b0);
    req = 4'b1000;
    step("rescue_back", 1'b1, 1'b1);
    req = 4'd0;
    idle_out("rescue");

    // force_on holds ON indefinitely
    force_on = 1'b1;
    step("force_e0", 1'b1, 1'b0);
    step("force_e1", 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step("force_hold", 1'b1, 1'b1);
    force_on = 1'b0;
    idle_out("force");

    // Asynchronous reset while ready is high
    wake_up("arst", 4'b0010);
    step("arst_on", 1'b1, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst.cg_en", {31'd0, cg_en}, 32'd0);
    check_eq("arst.ready", {31'd0, ready}, 32'd0);
    check_eq("arst.off",   {16'd0, off_cycles}, 32'd0);
    check_eq("arst.wake",  {24'd0, wake_events}, 32'd0);
    prev_cg = 1'b0; exp_off = 16'd0; exp_wake = 8'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wake_up("arst_rewake", 4'b0001);
    idle_out("arst_rewake");

    // Saturation of off_cycles, then clear coinciding with an OFF increment
    repeat (70000) @(posedge clk);
    #1;
    exp_off = 16'hFFFF;
    check_eq("sat.off", {16'd0, off_cycles}, 32'h0000FFFF);
    step("sat_hold", 1'b0, 1'b0);
    clr_stat = 1'b1;
    step("clr", 1'b0, 1'b0);
    clr_stat = 1'b0;
    step("clr_cnt1", 1'b0, 1'b0);
    step("clr_cnt2", 1'b0, 1'b0);
    check_eq("clr.off2", {16'd0, off_cycles}, 32'd2);

    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
